tusca_clima_fd: RTL

- Next-generation TUSCA climate datapath with NLEVELS run-time-writable temperature thresholds and a writable humidity limit.
- Produces a debounced temperature level, a fan PWM with slew-limited duty ramping, and a humidity relay with a minimum hold time.
- Sits between the sensor-sampling FSM (`sample_valid`, `temp`, `umidade`) and the fan/relay pins; limits are written over a simple config port by the control unit.

---
 rtl/tusca_clima_fd_pkg.sv | 12 +
 rtl/tusca_clima_fd_if.sv | 18 +
 rtl/tusca_clima_fd_pwm_rampa.sv | 32 +++
 rtl/tusca_clima_fd.sv | 85 ++++++++
 4 files changed

// File: rtl/tusca_clima_fd_pkg.sv
// tusca_pkg: shared constants and helpers for the TUSCA climate datapath.
// Samples/limits are {integer byte, tenths byte}, so plain unsigned compares order them correctly.
package tusca_pkg;
   localparam logic [63:0] LIM_RST = '1;
   localparam int ADDR_LIM_TEMP0 = 0;
   function automatic int lw(input int nlevels);
      return $clog2(nlevels + 1);
   endfunction
   function automatic int addr_lim_umidade(input int nlevels);
      return nlevels;
   endfunction
endpackage

// File: rtl/tusca_clima_fd_if.sv
// tusca_clima_fd_if: sample, config and actuator signals of the climate datapath.
interface tusca_clima_fd_if #(parameter int W = 16, parameter int NLEVELS = 4);
   localparam int AW = tusca_pkg::lw(NLEVELS);
   logic sample_valid;
   logic [W-1:0] temp;
   logic [W-1:0] umidade;
   logic cfg_we;
   logic [AW-1:0] cfg_addr;
   logic [W-1:0] cfg_data;
   logic [AW-1:0] nivel;
   logic pwm_ventoinha;
   logic rele;
   logic cfg_err;
   modport master(output sample_valid, temp, umidade, cfg_we, cfg_addr, cfg_data,
                  input nivel, pwm_ventoinha, rele, cfg_err);
   modport slave(input sample_valid, temp, umidade, cfg_we, cfg_addr, cfg_data,
                 output nivel, pwm_ventoinha, rele, cfg_err);
endinterface

// File: rtl/tusca_clima_fd_pwm_rampa.sv
// pwm_rampa: fixed-period PWM whose duty slews toward target only at period boundaries.
module pwm_rampa #(
   parameter int PERIOD = 100,
   parameter int RAMP_STEP = 5,
   localparam int DW = $clog2(PERIOD + 1)
) (
   input  logic clock,
   input  logic reset,
   input  logic [DW-1:0] target,
   output logic pwm_out,
   output logic [DW-1:0] duty_cur
);
   logic [DW-1:0] pcnt, up, dn, nxt;
   logic last;
   always_comb begin
      last = pcnt == DW'(PERIOD - 1);
      up = target - duty_cur;
      dn = duty_cur - target;
      nxt = target > duty_cur ? (int'(up) > RAMP_STEP ? duty_cur + DW'(RAMP_STEP) : target)
                              : (int'(dn) > RAMP_STEP ? duty_cur - DW'(RAMP_STEP) : target);
   end
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         pcnt <= '0;
         duty_cur <= '0;
         pwm_out <= 1'b0;
      end else begin
         pwm_out <= pcnt < duty_cur;
         pcnt <= last ? '0 : pcnt + 1'b1;
         duty_cur <= last ? nxt : duty_cur;
      end
endmodule

// File: rtl/tusca_clima_fd.sv
// tusca_clima_fd: debounced temperature level, ramped fan PWM and held humidity relay.
module tusca_clima_fd import tusca_pkg::*; #(
   parameter int W = 16,
   parameter int NLEVELS = 4,
   parameter int DWELL = 3,
   parameter int PWM_PERIOD = 100,
   parameter int RAMP_STEP = 5,
   parameter int MIN_HOLD = 1000
) (
   input logic clock,
   input logic reset,
   tusca_clima_fd_if.slave bus
);
   localparam int LW = lw(NLEVELS);
   localparam int CW = $clog2(DWELL + 1);
   localparam int HW = $clog2(MIN_HOLD + 1);
   localparam int DW = $clog2(PWM_PERIOD + 1);
   logic [W-1:0] s_temp, s_umidade, lim_umidade;
   logic [W-1:0] lim_temp [NLEVELS];
   logic [LW-1:0] nivel, cand, raw_level;
   logic [CW-1:0] cnt;
   logic [HW-1:0] hold;
   logic [DW-1:0] target, duty_unused;
   logic eval_v, mono_err, req, rele, cfg_err;
   always_comb begin
      raw_level = '0;
      mono_err = 1'b0;
      for (int k = 0; k < NLEVELS; k++) raw_level = raw_level + LW'(s_temp >= lim_temp[k]);
      for (int k = 1; k < NLEVELS; k++) mono_err = mono_err | (lim_temp[k-1] > lim_temp[k]);
      req = s_umidade > lim_umidade;
   end
   assign target = DW'(int'(nivel) * PWM_PERIOD / NLEVELS);
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         s_temp <= '0;
         s_umidade <= '0;
         eval_v <= 1'b0;
         for (int k = 0; k < NLEVELS; k++) lim_temp[k] <= LIM_RST[W-1:0];
         lim_umidade <= LIM_RST[W-1:0];
         nivel <= '0;
         cand <= '0;
         cnt <= '0;
         hold <= '0;
         rele <= 1'b0;
         cfg_err <= 1'b0;
      end else begin
         eval_v <= bus.sample_valid;
         if (bus.sample_valid) begin
            s_temp <= bus.temp;
            s_umidade <= bus.umidade;
         end
         for (int k = 0; k < NLEVELS; k++)
            if (bus.cfg_we && bus.cfg_addr == LW'(ADDR_LIM_TEMP0 + k)) lim_temp[k] <= bus.cfg_data;
         if (bus.cfg_we && bus.cfg_addr == LW'(addr_lim_umidade(NLEVELS))) lim_umidade <= bus.cfg_data;
         cfg_err <= mono_err;
         // A new level must be seen DWELL samples in a row; returning to nivel restarts the count
         if (eval_v) begin
            if (raw_level == nivel) cnt <= '0;
            else if (raw_level == cand) begin
               if (int'(cnt) + 1 >= DWELL) begin
                  nivel <= raw_level;
                  cnt <= '0;
               end else cnt <= cnt + 1'b1;
            end else begin
               cand <= raw_level;
               cnt <= CW'(1);
               if (DWELL == 1) nivel <= raw_level;
            end
         end
         if (req != rele && hold == HW'(MIN_HOLD)) begin
            rele <= req;
            hold <= '0;
         end else if (hold != HW'(MIN_HOLD)) hold <= hold + 1'b1;
      end
   pwm_rampa #(.PERIOD(PWM_PERIOD), .RAMP_STEP(RAMP_STEP)) u_pwm (
      .clock(clock),
      .reset(reset),
      .target(target),
      .pwm_out(bus.pwm_ventoinha),
      .duty_cur(duty_unused)
   );
   assign bus.nivel = nivel;
   assign bus.rele = rele;
   assign bus.cfg_err = cfg_err;
endmodule
